wb_write_arbiter: RTL



---
 rtl/wb_write_arbiter_if.sv | 51 +++++
 rtl/wb_write_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter_if: ALU/LSU/issue inputs and register-file write port bundle.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface wb_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;

  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [31:0]   lsu_data;

  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [31:0]   pending;

  logic          rf_we;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd;
  logic [CW-1:0] fifo_count;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd,
    output alu_ready, lsu_ready, pending,
    output rf_we, rf_wa, rf_wd, fifo_count
  );

  // Producer / observer side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd,
    input  alu_ready, lsu_ready, pending,
    input  rf_we, rf_wa, rf_wd, fifo_count
  );

endinterface

`default_nettype wire

// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter: merges ALU results and buffered load returns onto the single
// register-file write port and tracks outstanding loads. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wb_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_arbiter_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_DEPTH        = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] C_STARVE_LIMIT = SW'(STARVE_LIMIT);

  // Load-return buffer storage (data path only, no reset needed).
  logic [4:0]    r_mem_rd   [FIFO_DEPTH];
  logic [31:0]   r_mem_data [FIFO_DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_pending;
  logic          r_rf_we;
  logic [4:0]    r_rf_wa;
  logic [31:0]   r_rf_wd;

  logic          w_empty;
  logic          w_lsu_ready;
  logic          w_alu_ready;
  logic          w_push;
  logic          w_alu_win;
  logic          w_pop;
  logic          w_win;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [4:0]    w_win_rd;
  logic [31:0]   w_win_data;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_starve_nxt;
  logic [31:0]   w_pending_nxt;

  // Handshakes depend on registered state only, never on the valids.
  assign w_empty     = (r_count == '0);
  assign w_lsu_ready = (r_count != C_DEPTH);
  assign w_alu_ready = (r_starve != C_STARVE_LIMIT);

  assign w_push      = bus.lsu_valid && w_lsu_ready;
  assign w_alu_win   = bus.alu_valid && w_alu_ready;
  assign w_pop       = !w_alu_win && !w_empty;
  assign w_win       = w_alu_win || w_pop;

  assign w_head_rd   = r_mem_rd[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];
  assign w_win_rd    = w_alu_win ? bus.alu_rd   : w_head_rd;
  assign w_win_data  = w_alu_win ? bus.alu_data : w_head_data;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Losses are only counted while a load is actually waiting.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (w_alu_win && (r_starve != C_STARVE_LIMIT)) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end
    if (bus.issue_valid) begin
      w_pending_nxt[bus.issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= bus.lsu_rd;
      r_mem_data[r_wptr] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
      r_rf_we   <= 1'b0;
      r_rf_wa   <= '0;
      r_rf_wd   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count   <= w_count_nxt;
      r_starve  <= w_starve_nxt;
      r_pending <= w_pending_nxt;
      r_rf_we   <= w_win && (w_win_rd != 5'd0);
      if (w_win) begin
        r_rf_wa <= w_win_rd;
        r_rf_wd <= w_win_data;
      end
    end
  end

  assign bus.alu_ready  = w_alu_ready;
  assign bus.lsu_ready  = w_lsu_ready;
  assign bus.pending    = r_pending;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_wa      = r_rf_wa;
  assign bus.rf_wd      = r_rf_wd;
  assign bus.fifo_count = r_count;

endmodule

`default_nettype wire
